// File: rtl/cfs_push_arbiter_pkg.sv
// Shared types for the push arbiter: FSM state encoding.
package cfs_push_arbiter_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cfs_push_arbiter_if.sv
// Requester fan-in and FIFO push port bundle; slave side is the arbiter.
interface cfs_push_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_push_valid;
    logic [DATA_WIDTH-1:0]         fifo_push_data;
    logic                          fifo_push_ready;
    logic                          fifo_push_full;

    modport master (
        output req_valid, req_data, fifo_push_ready, fifo_push_full,
        input  req_ready, fifo_push_valid, fifo_push_data
    );

    modport slave (
        input  req_valid, req_data, fifo_push_ready, fifo_push_full,
        output req_ready, fifo_push_valid, fifo_push_data
    );
endinterface

// File: rtl/cfs_rr_picker.sv
// Round-robin picker: first valid requester at or after rr_ptr, one-hot.
// Latency: combinational; backpressure: none, pure function of inputs.
module cfs_rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         pick,
    output logic                       any
);
    int idx;

    // Walk the search order backwards so the earliest hit overwrites later ones.
    always_comb begin
        pick = '0;
        idx  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (valid[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
    end

    assign any = |valid;

endmodule

// File: rtl/cfs_push_arbiter.sv
// Bursty round-robin arbiter of NUM_REQ requesters onto one FIFO push port.
// Latency: req_valid to fifo_push_valid 2 cycles; backpressure: owner stalls on full or held output beat.
module cfs_push_arbiter
    import cfs_push_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic                             push_clk,
    input  logic                             reset_n,
    input  logic                             cfg_enable,
    cfs_push_arbiter_if.slave                bus,
    output logic [NUM_REQ-1:0]               grant,
    output logic [$clog2(BURST_LEN+1)-1:0]   burst_cnt
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_t             state, state_nxt;
    logic [IDX_W-1:0]       rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]       owner, owner_nxt, pick_idx;
    logic [NUM_REQ-1:0]     grant_nxt, pick;
    logic [CNT_W-1:0]       burst_cnt_nxt;
    logic                   pick_any;
    logic                   out_vld;
    logic [DATA_WIDTH-1:0]  out_dat, owner_dat;
    logic                   owner_vld, beat_rdy, beat_acc;

    cfs_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .valid  (bus.req_valid),
        .rr_ptr (rr_ptr),
        .pick   (pick),
        .any    (pick_any)
    );

    always_comb begin
        pick_idx  = '0;
        owner_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i])
                pick_idx = IDX_W'(i);
            if (owner == IDX_W'(i))
                owner_dat = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // grant is all-zero outside LOCK, so masking with it also gates ARB.
    assign owner_vld     = |(bus.req_valid & grant);
    assign beat_rdy      = (state == LOCK) && (!out_vld || bus.fifo_push_ready) && !bus.fifo_push_full;
    assign beat_acc      = beat_rdy && owner_vld;
    assign bus.req_ready = grant & {NUM_REQ{beat_rdy}};

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        case (state)
            ARB: begin
                if (cfg_enable && !bus.fifo_push_full && pick_any) begin
                    state_nxt     = LOCK;
                    grant_nxt     = pick;
                    owner_nxt     = pick_idx;
                    burst_cnt_nxt = '0;
                end
            end
            LOCK: begin
                if (beat_acc)
                    burst_cnt_nxt = burst_cnt + 1'b1;
                if ((beat_acc && burst_cnt_nxt == CNT_LAST) || !owner_vld || !cfg_enable) begin
                    state_nxt     = ARB;
                    grant_nxt     = '0;
                    burst_cnt_nxt = '0;
                    rr_ptr_nxt    = (owner == IDX_LAST) ? '0 : owner + 1'b1;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge push_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ARB;
            grant     <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Load wins over drain so a simultaneous drain+load leaves no bubble.
    always_ff @(posedge push_clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (beat_acc) begin
            out_vld <= 1'b1;
            out_dat <= owner_dat;
        end else if (bus.fifo_push_ready) begin
            out_vld <= 1'b0;
        end
    end

    assign bus.fifo_push_valid = out_vld;
    assign bus.fifo_push_data  = out_dat;

endmodule

// File: tb/tb_cfs_push_arbiter.sv
// Randomized and directed bench for cfs_push_arbiter with a transaction scoreboard.
module tb_cfs_push_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int BL = 4;

    logic          push_clk = 1'b0;
    logic          reset_n  = 1'b1;
    logic          cfg_enable;
    logic [NR-1:0] grant;
    logic [2:0]    burst_cnt;

    cfs_push_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    cfs_push_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .push_clk   (push_clk),
        .reset_n    (reset_n),
        .cfg_enable (cfg_enable),
        .bus        (bus),
        .grant      (grant),
        .burst_cnt  (burst_cnt)
    );

    always #5 push_clk = ~push_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // stimulus state
    logic [NR-1:0] vld;
    bit            en, full, prdy;
    logic [DW-1:0] dat [NR];
    int            seq [NR];

    // reference model state
    bit            m_locked, m_ovld, hold_chk;
    int            m_owner, m_rr, m_cnt;
    logic [DW-1:0] exp_q [$];
    int            dut_log [$];
    logic [NR-1:0] prev_g;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_locked = 0; m_ovld = 0; m_owner = 0; m_rr = 0; m_cnt = 0;
        exp_q.delete();
        prev_g = '0;
    endtask

    // One clock of the reference: check outputs for this cycle, then advance.
    task automatic model_cycle();
        logic [NR-1:0] e_grant, e_rdy;
        bit acc;
        bit found;
        e_grant = '0;
        e_rdy   = '0;
        if (m_locked) e_grant[m_owner] = 1'b1;
        if (m_locked && (!m_ovld || prdy) && !full) e_rdy[m_owner] = 1'b1;
        chk("grant", grant, e_grant);
        chk("req_ready", bus.req_ready, e_rdy);
        chk("push_valid", bus.fifo_push_valid, m_ovld);
        chk("burst_cnt", burst_cnt, m_cnt);
        if (hold_chk && exp_q.size() > 0) chk("held_data", bus.fifo_push_data, exp_q[0]);

        if (grant != 0 && prev_g == 0)
            for (int i = 0; i < NR; i++) if (grant[i]) dut_log.push_back(i);
        prev_g = grant;

        acc = m_locked && e_rdy[m_owner] && vld[m_owner];
        if (acc) begin
            exp_q.push_back(dat[m_owner]);
            m_ovld = 1;
        end else if (m_ovld && prdy) begin
            m_ovld = 0;
        end

        if (!m_locked) begin
            if (en && !full && vld != 0) begin
                found = 0;
                for (int k = 0; k < NR; k++)
                    if (!found && vld[(m_rr + k) % NR]) begin
                        m_owner = (m_rr + k) % NR;
                        found = 1;
                    end
                m_locked = 1;
                m_cnt = 0;
            end
        end else begin
            if (acc) begin
                m_cnt++;
                seq[m_owner]++;
            end
            if (m_cnt == BL || !vld[m_owner] || !en) begin
                m_locked = 0;
                m_rr = (m_owner + 1) % NR;
                m_cnt = 0;
            end
        end
    endtask

    task automatic cycle();
        for (int i = 0; i < NR; i++) begin
            dat[i] = {8'(i), 24'(seq[i])};
            bus.req_data[i*DW +: DW] = dat[i];
        end
        bus.req_valid       = vld;
        bus.fifo_push_full  = full;
        bus.fifo_push_ready = prdy;
        cfg_enable          = en;
        @(negedge push_clk);
        model_cycle();
        @(posedge push_clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_push_valid", bus.fifo_push_valid, 0);
        chk("rst_push_data", bus.fifo_push_data, 0);
        chk("rst_burst_cnt", burst_cnt, 0);
        model_reset();
        repeat (2) @(posedge push_clk);
        #1;
        reset_n = 1'b1;
    endtask

    always @(negedge push_clk) begin : monitor
        logic [DW-1:0] e;
        if (reset_n && bus.fifo_push_valid && bus.fifo_push_ready) begin
            if (exp_q.size() == 0) begin
                chk("queued_beats", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("push_data", bus.fifo_push_data, e);
            end
        end
    end

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int start;
        vld = '0; en = 1; full = 0; prdy = 1; hold_chk = 0;
        for (int i = 0; i < NR; i++) seq[i] = 0;
        bus.req_valid = '0; bus.req_data = '0;
        bus.fifo_push_full = 1'b0; bus.fifo_push_ready = 1'b0; cfg_enable = 1'b0;
        #2;
        do_reset();

        // All requesters streaming, FIFO always accepting.
        vld = '1; dut_log.delete();
        repeat (30) cycle();
        if (dut_log.size() >= 5)
            for (int i = 0; i < 5; i++) chk("grant_order", dut_log[i], exp_order[i]);
        else
            chk("grant_count", dut_log.size(), 5);

        // Lone requester 2 with two beats, then rr must resume at 3.
        do_reset();
        vld = '0;
        cycle();
        vld = 4'b0100;
        start = seq[2];
        for (int t = 0; t < 20 && seq[2] - start < 2; t++) cycle();
        chk("req2_beats", seq[2] - start, 2);
        vld = '0;
        repeat (4) cycle();
        dut_log.delete();
        vld = '1;
        repeat (3) cycle();
        if (dut_log.size() >= 1) chk("grant_after_req2", dut_log[0], 3);
        else chk("grant_after_req2_seen", dut_log.size(), 1);

        // FIFO full for 5 cycles mid-burst.
        for (int t = 0; t < 50 && !(m_locked && m_cnt == 2); t++) cycle();
        chk("reach_beat2", m_locked && m_cnt == 2, 1);
        full = 1; prdy = 0; hold_chk = 1;
        repeat (5) cycle();
        hold_chk = 0; full = 0; prdy = 1;
        repeat (20) cycle();

        // cfg_enable dropped while beat 2 is accepted.
        for (int t = 0; t < 50 && !(m_locked && m_cnt == 1); t++) cycle();
        chk("reach_beat1", m_locked && m_cnt == 1, 1);
        en = 0;
        repeat (6) cycle();
        en = 1;
        repeat (10) cycle();

        // Reset mid-burst with a held output beat.
        prdy = 0;
        for (int t = 0; t < 50 && !(m_locked && m_ovld); t++) cycle();
        chk("reach_held_beat", m_locked && m_ovld, 1);
        do_reset();
        prdy = 1; vld = '1; dut_log.delete();
        repeat (3) cycle();
        if (dut_log.size() >= 1) chk("grant_after_reset", dut_log[0], 0);
        else chk("grant_after_reset_seen", dut_log.size(), 1);

        // Randomized traffic.
        for (int t = 0; t < 3000; t++) begin
            vld  = NR'($urandom);
            en   = ($urandom_range(15) != 0);
            full = ($urandom_range(7) == 0);
            prdy = !full && ($urandom_range(3) != 0);
            cycle();
        end

        vld = '0; en = 1; full = 0; prdy = 1;
        repeat (10) cycle();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cfs_push_arbiter.md
CFS_PUSH_ARBITER -- requirements
Module: cfs_push_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one synchronization FIFO push port (legal 2..8).
REQ-002 Parameter DATA_WIDTH, default 32: width of each requester data word and of the FIFO push data.
REQ-003 Parameter BURST_LEN, default 4: maximum consecutive beats accepted from one requester per grant (legal >= 1).
REQ-004 push_clk  input  1  clock; same clock as the FIFO push domain.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 cfg_enable  input  1  when low, no new grant is issued.
REQ-007 req_valid  input  NUM_REQ  per-requester valid.
REQ-008 req_data  input  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_ready  output  NUM_REQ  per-requester accept; beat transfers when req_valid[i] & req_ready[i].
REQ-010 fifo_push_valid  output  1  to FIFO push_valid.
REQ-011 fifo_push_data  output  DATA_WIDTH  to FIFO push_data.
REQ-012 fifo_push_ready  input  1  from FIFO push_ready; FIFO ready is qualified by valid.
REQ-013 fifo_push_full  input  1  from FIFO push-domain full flag.
REQ-014 grant  output  NUM_REQ  one-hot current owner; all zero when not locked.
REQ-015 burst_cnt  output  $clog2(BURST_LEN+1)  beats accepted in the current grant.

Function
REQ-016 Two-state FSM: ARB and LOCK.
REQ-017 ARB: if cfg_enable=1, fifo_push_full=0 and any req_valid=1, the requester picked round-robin starting at rr_ptr becomes the owner; grant registers it and the FSM enters LOCK on the next edge with burst_cnt=0.
REQ-018 Round-robin: search order rr_ptr, rr_ptr+1, ... modulo NUM_REQ; first requester with valid high wins.
REQ-019 LOCK: req_ready[owner] = !out_valid | fifo_push_ready; req_ready of every other requester SHALL be 0; in ARB all req_ready SHALL be 0.
REQ-020 One-entry output register (out_valid, out_data) drives fifo_push_valid/fifo_push_data; it loads on an accepted beat and clears on fifo_push_valid & fifo_push_ready without a same-cycle load.
REQ-021 Simultaneous drain and load: the register takes the new beat, out_valid stays 1, no bubble.
REQ-022 fifo_push_valid SHALL NOT depend combinationally on fifo_push_ready.
REQ-023 Each accepted beat increments burst_cnt by 1.
REQ-024 LOCK exits to ARB on the edge where: the accepted beat makes burst_cnt reach BURST_LEN; or req_valid[owner]=0; or cfg_enable=0; grant clears and rr_ptr becomes (owner+1) mod NUM_REQ.
REQ-025 Latency: req_valid rises in ARB at cycle N -> grant at N+1 -> beat accepted at N+1 -> fifo_push_valid at N+2.
REQ-026 Minimum one ARB cycle between consecutive grants.
REQ-027 FIFO full in LOCK: out_valid holds, req_ready[owner]=0, burst_cnt holds; no data lost or duplicated.
REQ-028 Beat order into the FIFO SHALL equal acceptance order.
REQ-029 cfg_enable falling does not flush the output register; a pending beat still drains.

Reset
REQ-030 reset_n low: FSM=ARB, rr_ptr=0, grant=0, burst_cnt=0, out_valid=0, out_data=0, req_ready=0, fifo_push_valid=0.
REQ-031 Reset mid-burst discards any pending beat; after release requester 0 has first priority.

Structure
REQ-032 Package cfs_push_arbiter_pkg SHALL hold the FSM state enum typedef (ARB, LOCK).
REQ-033 Sub-module cfs_rr_picker: combinational round-robin picker (inputs valid vector and rr_ptr; outputs one-hot pick and any flag).

Verification
REQ-034 NUM_REQ=4, BURST_LEN=4, all four valid continuously, FIFO never full -> grant order 0,1,2,3,0; each burst exactly 4 beats; one ARB cycle between bursts.
REQ-035 Only requester 2 valid with 2 beats -> grant at N+1, fifo_push_valid at N+2 and N+3, return to ARB, rr_ptr=3.
REQ-036 fifo_push_full asserted for 5 cycles mid-burst -> req_ready[owner]=0, fifo_push_valid stays high with stable data, burst resumes with no loss or duplication.
REQ-037 cfg_enable dropped during beat 2 -> pending beat drains, grant clears next edge, no new grant until cfg_enable=1.
REQ-038 reset_n asserted mid-burst with out_valid=1 -> all outputs 0 immediately; after release with all valid, requester 0 is granted first.
